regfile: RTL and testbench

General-purpose register file for the five-stage MIPS integer pipeline: 32 × 32-bit registers, one synchronous write port fed by the write-back stage (`wd`/`wreg`/`wdata` produced by execute and carried through memory), and two combinational read ports serving the decode stage. It is the consumer end of the execute result path. It stores every committed result and returns operands to decode, including a result being written in the same cycle (write-to-read bypass). Register 0 is hardwired to zero.

---
 rtl/regfile.sv | 82 ++++++++
 tb/tb_regfile.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file for the MIPS integer
// pipeline. It has one synchronous write port, fed by write-back, and two
// combinational read ports, serving decode. A read of the register being
// written in the same cycle returns the new data through a bypass.
// Register 0 is hardwired to zero.
//
// Ports:
//   clk            rising-edge clock for writes
//   rst            asynchronous, active-high; clears every register
//   we/waddr/wdata write enable, destination register, write data
//   re1/raddr1     read enable / address, port 1 (rs)
//   rdata1         read data, port 1
//   re2/raddr2     read enable / address, port 2 (rt)
//   rdata2         read data, port 2
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);

  localparam int unsigned RegNum     = 32;
  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;

  logic [RegBus-1:0] regs_q [RegNum];
  logic [RegBus-1:0] regs_d [RegNum];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RegNum; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read priority: reset, address 0, disabled port, same-cycle bypass, array.
  function automatic logic [RegBus-1:0] read_port(
    input logic                  rd_en,
    input logic [RegAddrBus-1:0] rd_addr
  );
    logic [RegBus-1:0] val;
    val = '0;
    if (rst) begin
      val = '0;
    end else if (rd_addr == '0) begin
      val = '0;
    end else if (!rd_en) begin
      val = '0;
    end else if (we && (waddr == rd_addr)) begin
      val = wdata;
    end else begin
      val = regs_q[rd_addr];
    end
    return val;
  endfunction

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural contents, as the spec defines them.
  logic [31:0] model [32];

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  end

  // Reference state update: async clear on reset, otherwise commit the write.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
  end

  function automatic logic [31:0] expect_read(input logic en, input logic [4:0] a);
    if (rst)                  return 32'h0;
    if (a == 5'd0)            return 32'h0;
    if (!en)                  return 32'h0;
    if (we && waddr == a)     return wdata;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the write edge, compare both ports to the model.
  always @(negedge clk) begin
    check("port1_model", rdata1, expect_read(re1, raddr1));
    check("port2_model", rdata2, expect_read(re2, raddr2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #2 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset asserted between edges clears r5 immediately.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
    #1 check("r5_written", rdata1, 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1 check("r5_async_reset", rdata1, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("r5_after_release", rdata1, 32'h0);

    // Write then read on both ports; disabled port reads zero.
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1 check("r7_port1", rdata1, 32'h12345678);
    check("r7_port2", rdata2, 32'h12345678);
    re2 = 1'b0;
    #1 check("r7_port2_disabled", rdata2, 32'h0);

    // r0 ignores writes and never bypasses.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; re1 = 1'b1; raddr1 = 5'd0;
    #1 check("r0_same_cycle", rdata1, 32'h0);
    tick();
    we = 1'b0;
    #1 check("r0_later", rdata1, 32'h0);

    // Bypass of r3 while r4 is untouched.
    we = 1'b1; waddr = 5'd3; wdata = 32'h1;
    tick();
    wdata = 32'hA5A5A5A5; re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
    #1 check("r3_bypass", rdata1, 32'hA5A5A5A5);
    check("r4_unaffected", rdata2, 32'h0);
    tick();
    we = 1'b0;
    #1 check("r3_after_edge", rdata1, 32'hA5A5A5A5);

    // Write held across an edge during reset is dropped.
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    tick();
    rst = 1'b0; we = 1'b0; re1 = 1'b1; raddr1 = 5'd9;
    #1 check("r9_write_in_reset", rdata1, 32'h0);
    tick();
    check("r9_later", rdata1, 32'h0);

    // Sweep r1..r31, then read pairwise.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'h100 + 32'(i);
      tick();
    end
    we = 1'b0; re1 = 1'b1; re2 = 1'b1;
    for (int i = 0; i < 32; i += 2) begin
      raddr1 = 5'(i); raddr2 = 5'(i + 1);
      #1;
      check("sweep_p1", rdata1, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
      check("sweep_p2", rdata2, 32'h100 + 32'(i + 1));
      tick();
    end

    // Random traffic; addresses biased to a small set so bypasses occur often.
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 63) == 0);
      we     = $urandom_range(0, 3) != 0;
      waddr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wdata  = $urandom;
      re1    = $urandom_range(0, 7) != 0;
      re2    = $urandom_range(0, 7) != 0;
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 3));
      raddr2 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
      tick();
    end

    idle_inputs();
    rst = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
